// File: rtl/galaksija_tape_player.sv
// rtl/galaksija_tape_player.sv - tape buffer playback sequencer and pulse serialiser
module galaksija_tape_player #(
  parameter int ADDR_W       = 14,
  parameter int SLOT_CYCLES  = 588,
  parameter int PULSE_CYCLES = 164,
  parameter int GAP_CYCLES   = 13000,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_active,
  input  logic              load_wr,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              rewind,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic              tape_bit,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W:0]   tape_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_D,
    S_BITS,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LEN = CNT_W'(PULSE_CYCLES);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   pos_q, pos_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        slot_q, slot_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
  logic              tape_bit_q, tape_bit_d;
  logic              done_q, done_d;
  logic              load_q;

  logic              load_first;
  logic [ADDR_W:0]   len_base;
  logic [ADDR_W:0]   addr_p1;
  logic [ADDR_W:0]   pos_next;
  logic              slot_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tape_bit_q <= 1'b1;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      tape_bit_q <= tape_bit_d;
      done_q     <= done_d;
      load_q     <= load_active;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    load_first  = load_active & ~load_q;
    len_base    = load_first ? '0 : len_q;
    addr_p1     = {1'b0, load_addr} + (ADDR_W+1)'(1);
    pos_next    = pos_q + (ADDR_W+1)'(1);

    // Length is the highest address written plus one, so out-of-order writes are fine
    if (load_active) begin
      len_d = len_base;
      if (load_wr && (addr_p1 > len_base)) begin
        len_d = addr_p1;
      end
    end

    if (load_active) begin
      state_d = S_IDLE;
      if (load_first) begin
        pos_d = '0;
      end
    end else if (rewind) begin
      state_d = S_IDLE;
      pos_d   = '0;
    end else if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pos_q < len_q) begin
            state_d = S_FETCH_A;
          end
        end
        S_FETCH_A: state_d = S_FETCH_D;
        S_FETCH_D: begin
          byte_d  = buf_data;
          bit_d   = '0;
          slot_d  = '0;
          cnt_d   = '0;
          state_d = S_BITS;
        end
        S_BITS: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d = '0;
            if (slot_q == 2'd3) begin
              slot_d = '0;
              if (bit_q == 3'd7) begin
                state_d = S_GAP;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end else begin
              slot_d = slot_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            pos_d   = pos_next;
            state_d = (pos_next == len_q) ? S_DONE : S_FETCH_A;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from next-state values so the registered level lines up with the state
    slot_active = (slot_d == 2'd0) || ((slot_d == 2'd2) && byte_d[bit_d]);
    tape_bit_d  = !((state_d == S_BITS) && slot_active && (cnt_d < PULSE_LEN));
    done_d      = (state_d == S_DONE);
  end

  assign buf_addr = pos_q[ADDR_W-1:0];
  assign tape_bit = tape_bit_q;
  assign done     = done_q;
  assign tape_len = len_q;
  assign playing  = (state_q == S_FETCH_A) || (state_q == S_FETCH_D) ||
                    (state_q == S_BITS) || (state_q == S_GAP);

endmodule

// File: tb/tb_galaksija_tape_player.sv
// tb/tb_galaksija_tape_player.sv - directed vector bench for galaksija_tape_player
module tb_galaksija_tape_player;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              load_active;
  logic              load_wr;
  logic [ADDR_W-1:0] load_addr;
  logic              rewind;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              tape_bit;
  logic              playing;
  logic              done;
  logic [ADDR_W:0]   tape_len;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   k;
    logic tb;
    logic pl;
    logic dn;
  } vec_t;

  vec_t vecs [18];

  galaksija_tape_player #(
    .ADDR_W(ADDR_W),
    .SLOT_CYCLES(8),
    .PULSE_CYCLES(2),
    .GAP_CYCLES(20),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load_active(load_active),
    .load_wr(load_wr),
    .load_addr(load_addr),
    .rewind(rewind),
    .buf_addr(buf_addr),
    .buf_data(buf_data),
    .tape_bit(tape_bit),
    .playing(playing),
    .done(done),
    .tape_len(tape_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) buf_data <= mem[buf_addr];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_begin();
    load_active = 1'b1;
    step(1);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    load_wr   = 1'b1;
    load_addr = ADDR_W'(a);
    mem[a]    = d;
    step(1);
    load_wr   = 1'b0;
  endtask

  task automatic load_end();
    load_active = 1'b0;
    step(1);
  endtask

  initial begin
    int vi;
    int lows;
    int done_k;

    vecs[0]  = '{1,   1'b1, 1'b1, 1'b0};
    vecs[1]  = '{2,   1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3,   1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4,   1'b0, 1'b1, 1'b0};
    vecs[4]  = '{5,   1'b1, 1'b1, 1'b0};
    vecs[5]  = '{11,  1'b1, 1'b1, 1'b0};
    vecs[6]  = '{19,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{20,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{21,  1'b1, 1'b1, 1'b0};
    vecs[9]  = '{27,  1'b1, 1'b1, 1'b0};
    vecs[10] = '{35,  1'b0, 1'b1, 1'b0};
    vecs[11] = '{51,  1'b1, 1'b1, 1'b0};
    vecs[12] = '{67,  1'b0, 1'b1, 1'b0};
    vecs[13] = '{258, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{259, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{278, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{279, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{285, 1'b1, 1'b0, 1'b1};

    reset       = 1'b1;
    enable      = 1'b0;
    load_active = 1'b0;
    load_wr     = 1'b0;
    load_addr   = '0;
    rewind      = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("rst tape_bit", 32'(tape_bit), 32'd1);
    chk("rst playing", 32'(playing), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst tape_len", 32'(tape_len), 32'd0);
    chk("rst buf_addr", 32'(buf_addr), 32'd0);
    enable = 1'b1;
    step(5);
    chk("empty idle playing", 32'(playing), 32'd0);

    // single byte 0x01
    enable = 1'b0;
    load_begin();
    wr(0, 8'h01);
    load_end();
    chk("len1", 32'(tape_len), 32'd1);
    enable = 1'b1;
    vi = 0;
    lows = 0;
    done_k = -1;
    for (int k = 1; k <= 285; k++) begin
      step(1);
      if (!tape_bit) lows++;
      if (done && done_k < 0) done_k = k;
      if (vi < 18 && vecs[vi].k == k) begin
        chk($sformatf("vec%0d tape_bit", vi), 32'(tape_bit), 32'(vecs[vi].tb));
        chk($sformatf("vec%0d playing", vi), 32'(playing), 32'(vecs[vi].pl));
        chk($sformatf("vec%0d done", vi), 32'(done), 32'(vecs[vi].dn));
        vi++;
      end
    end
    chk("byte01 low cycles", 32'(lows), 32'd18);
    chk("byte01 done cycle", 32'(done_k), 32'd279);

    // three bytes written out of order
    enable = 1'b0;
    step(1);
    load_begin();
    wr(2, 8'hA5);
    wr(0, 8'h3C);
    wr(1, 8'hFF);
    load_end();
    chk("len3", 32'(tape_len), 32'd3);
    enable = 1'b1;
    lows = 0;
    done_k = -1;
    for (int k = 1; k <= 840; k++) begin
      step(1);
      if (!tape_bit) lows++;
      if (done && done_k < 0) done_k = k;
      if ((k % 278) == 1 && k < 834) begin
        chk($sformatf("fetch addr k%0d", k), 32'(buf_addr), 32'(k / 278));
        chk($sformatf("fetch playing k%0d", k), 32'(playing), 32'd1);
      end
    end
    chk("3byte low cycles", 32'(lows), 32'd80);
    chk("3byte done cycle", 32'(done_k), 32'd835);

    // enable drop mid-byte and resume
    enable = 1'b0;
    step(1);
    rewind = 1'b1;
    step(1);
    rewind = 1'b0;
    chk("rewind idle addr", 32'(buf_addr), 32'd0);
    chk("rewind idle done", 32'(done), 32'd0);
    enable = 1'b1;
    step(281);
    chk("byte1 pulse low", 32'(tape_bit), 32'd0);
    chk("byte1 playing", 32'(playing), 32'd1);
    enable = 1'b0;
    step(1);
    chk("drop tape_bit", 32'(tape_bit), 32'd1);
    chk("drop playing", 32'(playing), 32'd0);
    chk("drop addr", 32'(buf_addr), 32'd1);
    step(3);
    enable = 1'b1;
    step(1);
    chk("resume playing", 32'(playing), 32'd1);
    chk("resume addr", 32'(buf_addr), 32'd1);
    step(555);
    chk("resume done early", 32'(done), 32'd0);
    step(1);
    chk("resume done", 32'(done), 32'd1);

    // rewind from DONE with enable held high
    rewind = 1'b1;
    step(1);
    rewind = 1'b0;
    chk("rw done", 32'(done), 32'd0);
    chk("rw playing", 32'(playing), 32'd0);
    chk("rw addr", 32'(buf_addr), 32'd0);
    step(1);
    chk("rw restart playing", 32'(playing), 32'd1);
    chk("rw restart addr", 32'(buf_addr), 32'd0);
    step(100);
    chk("rw mid playing", 32'(playing), 32'd1);
    load_active = 1'b1;
    step(1);
    chk("load abort playing", 32'(playing), 32'd0);
    chk("load abort tape_bit", 32'(tape_bit), 32'd1);
    chk("load abort len", 32'(tape_len), 32'd0);
    rewind = 1'b1;
    step(1);
    rewind = 1'b0;
    load_active = 1'b0;
    step(3);
    chk("empty after load", 32'(playing), 32'd0);

    // full buffer length, max tracking
    load_begin();
    wr((1 << ADDR_W) - 1, 8'h5A);
    wr(5, 8'h00);
    chk("full len", 32'(tape_len), 32'(1 << ADDR_W));
    load_end();
    chk("full playing", 32'(playing), 32'd1);
    chk("full addr", 32'(buf_addr), 32'd0);
    chk("full len held", 32'(tape_len), 32'(1 << ADDR_W));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/galaksija_tape_player.md
Name: galaksija_tape_player

Overview:
Sequencer for the tape playback path. Tracks how many bytes the loader has written into the dual-port tape buffer, then reads it back byte by byte and serialises each byte into a timed pulse train. The result is the tape input bit sampled by the CPU at the keyboard/latch address. It replaces free-running counter playback with an explicit state machine that has defined start, stop, rewind and end-of-tape behaviour.

Parameters:
ADDR_W, 14, tape buffer address width (16 KB buffer)
SLOT_CYCLES, 588, clock cycles per pulse slot; 4 slots per bit
PULSE_CYCLES, 164, low-pulse length at the start of an active slot; must be < SLOT_CYCLES
GAP_CYCLES, 13000, idle-high cycles after each byte
CNT_W, 16, width of the timing counter; must hold max(SLOT_CYCLES, GAP_CYCLES)

Ports:
clk  in  1  system clock (CPU clock domain)
reset  in  1  synchronous, active-high reset
enable  in  1  playback enable (OSD tape option); low forces IDLE
load_active  in  1  loader download in progress
load_wr  in  1  loader write strobe into the tape buffer
load_addr  in  ADDR_W  loader write address
rewind  in  1  single-cycle pulse: restart from byte 0
buf_addr  out  ADDR_W  tape buffer read address (port B)
buf_data  in  8  tape buffer read data; valid 1 cycle after buf_addr
tape_bit  out  1  serial tape level; idle high, pulses low
playing  out  1  high while in FETCH/BITS/GAP
done  out  1  high in DONE (end of tape reached)
tape_len  out  ADDR_W+1  number of bytes loaded

Behaviour:
- Reset: state IDLE, tape_bit=1, playing=0, done=0, buf_addr=0, tape_len=0, pos=0.
- Length tracking: on the first cycle with load_active high, tape_len<=0 and pos<=0. While load_active and load_wr, tape_len<=max(tape_len, load_addr+1). The width is ADDR_W+1, so a full buffer gives tape_len = 2^ADDR_W.
- load_active high overrides everything: state IDLE, tape_bit=1.
- States:
  - IDLE: tape_bit=1. Go to FETCH_A when enable=1, load_active=0 and pos<tape_len. If tape_len=0, stay in IDLE.
  - FETCH_A: drive buf_addr=pos for 1 cycle, then FETCH_D.
  - FETCH_D: latch buf_data into the shift register. Set bit index=0, slot=0, counter=0. Go to BITS.
  - BITS: counter runs 0..SLOT_CYCLES-1 per slot; slot runs 0..3 per bit; bits go LSB first, 0..7.
    - A slot is active when slot==0, or slot==2 with the current bit =1.
    - tape_bit=0 while the slot is active and counter<PULSE_CYCLES; otherwise tape_bit=1.
    - After bit 7, slot 3, last cycle: go to GAP.
  - GAP: tape_bit=1 for GAP_CYCLES cycles. Then pos<=pos+1. If pos+1==tape_len go to DONE, else FETCH_A.
  - DONE: done=1, tape_bit=1. Hold until rewind, enable low, or load_active.
- Byte period = 2 + 32*SLOT_CYCLES + GAP_CYCLES cycles.
- enable falling in any state: go to IDLE next cycle, tape_bit=1. pos is retained, so re-enabling resumes at the start of the current byte (pos).
- rewind: pos<=0, done<=0, go to IDLE. From IDLE, playback restarts if enable=1. rewind during load_active is ignored.
- Priority, highest first: reset > load_active > rewind > enable low > normal sequencing.
- playing=1 exactly in FETCH_A, FETCH_D, BITS, GAP.
- tape_bit and done are registered outputs. buf_addr is registered and equals pos.

Test Plan:
- Reset, then idle → tape_bit=1, playing=0, done=0, tape_len=0. enable=1 with no load → stays in IDLE.
- Load 1 byte 0x01 at addr 0 (SLOT=8, PULSE=2, GAP=20), then enable → bit0 gives low pulses of 2 cycles at slot 0 and slot 2; bits1-7 give one pulse each. done rises 278 cycles after leaving IDLE.
- Load 3 bytes, writes to addrs 2,0,1 out of order → tape_len=3; buf_addr reads 0,1,2 in order; done after 3×278 cycles.
- Drop enable mid-BITS of byte 1 → tape_bit=1 on the next cycle and state is IDLE. Re-enable → FETCH_A with buf_addr=1.
- Pulse rewind while in DONE → done=0, playback restarts at buf_addr=0. Assert load_active mid-playback → IDLE, tape_len cleared, tape_bit=1.
- Write to load_addr=2^ADDR_W-1 → tape_len=2^ADDR_W with no wrap; pos reaching the last byte ends in DONE, not a wrap to 0.
